// File: rtl/alu_issue_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two issue requesters,
// with a one-entry result register toward writeback that honours backpressure.
module alu_issue_arbiter #(
  parameter int OPERAND_SIZE     = 32,
  parameter int REG_ADDRESS_SIZE = 5,
  parameter int OP_SIZE          = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic [OP_SIZE-1:0]        req0_op,
  input  logic [OPERAND_SIZE-1:0]   req0_operand1,
  input  logic [OPERAND_SIZE-1:0]   req0_operand2,
  input  logic [REG_ADDRESS_SIZE:0] req0_static,
  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic [OP_SIZE-1:0]        req1_op,
  input  logic [OPERAND_SIZE-1:0]   req1_operand1,
  input  logic [OPERAND_SIZE-1:0]   req1_operand2,
  input  logic [REG_ADDRESS_SIZE:0] req1_static,
  output logic [OP_SIZE-1:0]        alu_op,
  output logic [OPERAND_SIZE-1:0]   alu_operand1,
  output logic [OPERAND_SIZE-1:0]   alu_operand2,
  output logic [REG_ADDRESS_SIZE:0] alu_static_in,
  input  logic [OPERAND_SIZE-1:0]   alu_result,
  input  logic [REG_ADDRESS_SIZE:0] alu_static_out,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [OPERAND_SIZE-1:0]   res_result,
  output logic [REG_ADDRESS_SIZE:0] res_static,
  output logic                      res_src,
  output logic                      dbg_state
);

  // Handshake: a transfer happens in a cycle where valid && ready are both high;
  // ready never feeds back into valid, and payload is held stable until accepted.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                      state_q, state_d;
  logic                        ptr_q, ptr_d;
  logic [OPERAND_SIZE-1:0]     result_q, result_d;
  logic [REG_ADDRESS_SIZE:0]   static_q, static_d;
  logic                        src_q, src_d;
  logic                        can_accept;
  logic                        grant0, grant1;

  assign res_valid  = (state_q == FULL);
  assign res_result = result_q;
  assign res_static = static_q;
  assign res_src    = src_q;
  assign dbg_state  = state_q;

  assign can_accept = !res_valid || res_ready;

  // Under contention the pointer picks the winner; a lone requester always wins.
  assign grant0 = !reset && can_accept && req0_valid && (!req1_valid || !ptr_q);
  assign grant1 = !reset && can_accept && req1_valid && (!req0_valid ||  ptr_q);

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    alu_op        = '0;
    alu_operand1  = '0;
    alu_operand2  = '0;
    alu_static_in = '0;
    if (grant0) begin
      alu_op        = req0_op;
      alu_operand1  = req0_operand1;
      alu_operand2  = req0_operand2;
      alu_static_in = req0_static;
    end else if (grant1) begin
      alu_op        = req1_op;
      alu_operand1  = req1_operand1;
      alu_operand2  = req1_operand2;
      alu_static_in = req1_static;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    result_d = result_q;
    static_d = static_q;
    src_d    = src_q;
    if (grant0 || grant1) begin
      // A grant while FULL implies res_ready, so the old entry drains this cycle.
      state_d  = FULL;
      ptr_d    = grant0;
      result_d = alu_result;
      static_d = alu_static_out;
      src_d    = grant1;
    end else if (state_q == FULL && res_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= EMPTY;
      ptr_q    <= 1'b0;
      result_q <= '0;
      static_q <= '0;
      src_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      result_q <= result_d;
      static_q <= static_d;
      src_q    <= src_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: directed cycle table followed by randomized traffic
// compared against a transaction-level reference model.
module tb_alu_issue_arbiter;

  localparam int W  = 32;
  localparam int RA = 5;
  localparam int SW = RA + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [0:0]    req0_op, req1_op;
  logic [W-1:0]  req0_operand1, req0_operand2, req1_operand1, req1_operand2;
  logic [SW-1:0] req0_static, req1_static;
  logic [0:0]    alu_op;
  logic [W-1:0]  alu_operand1, alu_operand2, alu_result;
  logic [SW-1:0] alu_static_in, alu_static_out;
  logic          res_valid, res_ready;
  logic [W-1:0]  res_result;
  logic [SW-1:0] res_static;
  logic          res_src;
  logic          dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_arbiter #(.OPERAND_SIZE(W), .REG_ADDRESS_SIZE(RA), .OP_SIZE(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_operand1(req0_operand1), .req0_operand2(req0_operand2), .req0_static(req0_static),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_operand1(req1_operand1), .req1_operand2(req1_operand2), .req1_static(req1_static),
    .alu_op(alu_op), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_static_in(alu_static_in), .alu_result(alu_result), .alu_static_out(alu_static_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_result(res_result),
    .res_static(res_static), .res_src(res_src), .dbg_state(dbg_state)
  );

  // Behavioural ALU: op 0 adds, op 1 subtracts; the tag passes straight through.
  function automatic logic [W-1:0] alu_fn(logic op, logic [W-1:0] a, logic [W-1:0] b);
    return op ? a - b : a + b;
  endfunction

  assign alu_result     = alu_fn(alu_op[0], alu_operand1, alu_operand2);
  assign alu_static_out = alu_static_in;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic v0, input logic v1, input logic rr);
    reset      = rst;
    req0_valid = v0;
    req1_valid = v1;
    res_ready  = rr;
  endtask

  // Compare ALU drive against the expected winner (-1 = nobody).
  task automatic chk_alu(input int winner);
    logic          e_op;
    logic [W-1:0]  e_a, e_b;
    logic [SW-1:0] e_s;
    e_op = 1'b0; e_a = '0; e_b = '0; e_s = '0;
    if (winner == 0) begin
      e_op = req0_op[0]; e_a = req0_operand1; e_b = req0_operand2; e_s = req0_static;
    end else if (winner == 1) begin
      e_op = req1_op[0]; e_a = req1_operand1; e_b = req1_operand2; e_s = req1_static;
    end
    chk("alu_op", {63'd0, alu_op[0]}, {63'd0, e_op});
    chk("alu_operand1", {32'd0, alu_operand1}, {32'd0, e_a});
    chk("alu_operand2", {32'd0, alu_operand2}, {32'd0, e_b});
    chk("alu_static_in", {58'd0, alu_static_in}, {58'd0, e_s});
  endtask

  typedef struct {
    bit rst, v0, v1, rr;
    bit e_r0, e_r1;
    bit e_rv, e_src, e_zero;
  } tv_t;

  tv_t tv[$];

  // Reference-model state for the random phase.
  bit            m_valid, m_ptr, m_src;
  logic [W-1:0]  m_res;
  logic [SW-1:0] m_static;
  logic [W-1:0]  exp_q[$];

  initial begin
    // rst v0 v1 rr | r0 r1 | rv src zero  (rv/src are the registered outputs before this edge)
    tv.push_back('{0,1,0,1, 1,0, 0,0,1});
    tv.push_back('{0,0,0,1, 0,0, 1,0,0});
    tv.push_back('{1,0,0,1, 0,0, 0,0,0});
    tv.push_back('{0,1,1,1, 1,0, 0,0,1});
    tv.push_back('{0,1,1,1, 0,1, 1,0,0});
    tv.push_back('{0,1,1,1, 1,0, 1,1,0});
    tv.push_back('{0,1,1,1, 0,1, 1,0,0});
    tv.push_back('{0,1,1,0, 0,0, 1,1,0});
    tv.push_back('{0,1,1,0, 0,0, 1,1,0});
    tv.push_back('{0,1,1,0, 0,0, 1,1,0});
    tv.push_back('{0,1,1,1, 1,0, 1,1,0});
    tv.push_back('{0,0,1,1, 0,1, 1,0,0});
    tv.push_back('{0,0,1,1, 0,1, 1,1,0});
    tv.push_back('{0,1,1,1, 1,0, 1,1,0});
    tv.push_back('{0,1,1,1, 0,1, 1,0,0});
    tv.push_back('{1,1,1,1, 0,0, 1,1,0});
    tv.push_back('{0,1,1,1, 1,0, 0,0,1});
    tv.push_back('{0,0,0,1, 0,0, 1,0,0});
    tv.push_back('{0,0,1,1, 0,1, 0,0,0});
    tv.push_back('{0,0,0,1, 0,0, 1,1,0});
    tv.push_back('{0,0,0,0, 0,0, 0,1,0});

    req0_op = 1'b0; req0_operand1 = 32'd5;  req0_operand2 = 32'd3; req0_static = 6'b1_00100;
    req1_op = 1'b1; req1_operand1 = 32'd20; req1_operand2 = 32'd7; req1_static = 6'b0_11111;
    drive(1, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    foreach (tv[i]) begin
      int w;
      drive(tv[i].rst, tv[i].v0, tv[i].v1, tv[i].rr);
      #4;
      w = tv[i].e_r0 ? 0 : (tv[i].e_r1 ? 1 : -1);
      chk($sformatf("t%0d req0_ready", i), {63'd0, req0_ready}, {63'd0, tv[i].e_r0});
      chk($sformatf("t%0d req1_ready", i), {63'd0, req1_ready}, {63'd0, tv[i].e_r1});
      chk($sformatf("t%0d res_valid", i), {63'd0, res_valid}, {63'd0, tv[i].e_rv});
      chk($sformatf("t%0d dbg_state", i), {63'd0, dbg_state}, {63'd0, tv[i].e_rv});
      chk_alu(w);
      if (tv[i].e_zero) begin
        chk($sformatf("t%0d res_result_rst", i), {32'd0, res_result}, 64'd0);
        chk($sformatf("t%0d res_static_rst", i), {58'd0, res_static}, 64'd0);
        chk($sformatf("t%0d res_src_rst", i), {63'd0, res_src}, 64'd0);
      end else if (tv[i].e_rv) begin
        chk($sformatf("t%0d res_src", i), {63'd0, res_src}, {63'd0, tv[i].e_src});
        chk($sformatf("t%0d res_result", i), {32'd0, res_result},
            tv[i].e_src ? 64'd13 : 64'd8);
        chk($sformatf("t%0d res_static", i), {58'd0, res_static},
            tv[i].e_src ? 64'h1f : 64'h24);
      end
      @(posedge clk);
      #1;
    end

    // Random phase: start from a clean reset so the model begins in a known state.
    drive(1, 0, 0, 1);
    @(posedge clk);
    #1;
    m_valid = 0; m_ptr = 0; m_src = 0; m_res = '0; m_static = '0;
    for (int c = 0; c < 600; c++) begin
      bit rst, rr;
      bit v0, v1;
      int winner;
      bit can;
      v0 = req0_valid;
      v1 = req1_valid;
      if (!v0) begin
        v0 = ($urandom_range(0, 2) != 0);
        if (v0) begin
          req0_op = 1'($urandom_range(0, 1)); req0_operand1 = $urandom; req0_operand2 = $urandom;
          req0_static = 6'($urandom_range(0, 63));
        end
      end
      if (!v1) begin
        v1 = ($urandom_range(0, 2) != 0);
        if (v1) begin
          req1_op = 1'($urandom_range(0, 1)); req1_operand1 = $urandom; req1_operand2 = $urandom;
          req1_static = 6'($urandom_range(0, 63));
        end
      end
      rr  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 79) == 0);
      drive(rst, v0, v1, rr);

      can = !m_valid || rr;
      winner = -1;
      if (!rst && can) begin
        if (v0 && v1) winner = int'(m_ptr);
        else if (v0)  winner = 0;
        else if (v1)  winner = 1;
      end

      #4;
      chk("rnd req0_ready", {63'd0, req0_ready}, {63'd0, winner == 0});
      chk("rnd req1_ready", {63'd0, req1_ready}, {63'd0, winner == 1});
      chk("rnd res_valid", {63'd0, res_valid}, {63'd0, m_valid});
      chk("rnd res_result", {32'd0, res_result}, {32'd0, m_res});
      chk("rnd res_static", {58'd0, res_static}, {58'd0, m_static});
      chk("rnd res_src", {63'd0, res_src}, {63'd0, m_src});
      chk_alu(winner);

      if (winner >= 0)
        exp_q.push_back(winner == 0 ? alu_fn(req0_op[0], req0_operand1, req0_operand2)
                                    : alu_fn(req1_op[0], req1_operand1, req1_operand2));

      @(posedge clk);
      if (rst) begin
        m_valid = 0; m_ptr = 0; m_src = 0; m_res = '0; m_static = '0;
        exp_q.delete();
      end else if (winner >= 0) begin
        m_valid  = 1;
        m_src    = (winner == 1);
        m_ptr    = (winner == 0);
        m_res    = exp_q.pop_front();
        m_static = (winner == 0) ? req0_static : req1_static;
      end else if (rr) begin
        m_valid = 0;
      end
      #1;
      if (winner == 0) req0_valid = 1'b0;
      if (winner == 1) req1_valid = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
- Shares the single combinational ALU between two issue requesters (req0, req1) using round-robin arbitration and valid/ready handshakes.
- Drives the ALU operand, operation and static-tag inputs from the granted requester.
- Captures the ALU result and the passed-through static tag in a one-entry output register that feeds writeback, with backpressure.
- Sits between the issue stage and the ALU/writeback path.

Parameters:
- OPERAND_SIZE, 32, operand/result width.
- REG_ADDRESS_SIZE, 5, register address width. The static tag is REG_ADDRESS_SIZE+1 bits: dest reg address plus a write-enable bit at the MSB.
- OP_SIZE, 1, ALU operation code width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 granted this cycle.
- req0_op  in  OP_SIZE  operation code.
- req0_operand1  in  OPERAND_SIZE  first operand.
- req0_operand2  in  OPERAND_SIZE  second operand.
- req0_static  in  REG_ADDRESS_SIZE+1  tag.
- req1_valid, req1_ready, req1_op, req1_operand1, req1_operand2, req1_static: same as the req0 ports, for requester 1.
- alu_op  out  OP_SIZE  to ALU.
- alu_operand1  out  OPERAND_SIZE  to ALU.
- alu_operand2  out  OPERAND_SIZE  to ALU.
- alu_static_in  out  REG_ADDRESS_SIZE+1  to ALU.
- alu_result  in  OPERAND_SIZE  from ALU (combinational).
- alu_static_out  in  REG_ADDRESS_SIZE+1  from ALU.
- res_valid  out  1  output register holds a result.
- res_ready  in  1  writeback accepts the result.
- res_result  out  OPERAND_SIZE  registered result.
- res_static  out  REG_ADDRESS_SIZE+1  registered tag.
- res_src  out  1  requester that produced the result (0/1).

Behaviour:
- Reset (synchronous, active-high): res_valid=0, res_result=0, res_static=0, res_src=0, priority pointer=0 (req0 favoured). While reset is high, req0_ready=req1_ready=0 and nothing is captured. Reset mid-operation discards any held result.
- can_accept = !res_valid || res_ready (combinational).
- Grant (combinational, at most one per cycle), only when can_accept=1:
  - Exactly one requester valid: grant it.
  - Both valid: grant the requester named by the priority pointer.
  - Neither valid: no grant.
- reqN_ready = grantN.
  - reqN_ready may depend on reqN_valid and res_ready.
  - Requesters must not make valid depend on ready.
- Handshake completes when reqN_valid && reqN_ready in the same cycle.
  - A requester must hold valid and its payload stable until accepted.
- Pointer update: on any grant, pointer := index of the non-granted requester. Otherwise unchanged, including when stalled by backpressure.
  - Guarantees strict alternation under contention.
  - Wait bound: at most 1 grant to the other requester.
- ALU drive: alu_* = granted requester's op/operands/static. With no grant, all alu_* outputs are driven to 0.
- Output register: two-state FSM, EMPTY and FULL.
  - EMPTY, grant -> FULL; capture alu_result, alu_static_out, res_src=granted index.
  - EMPTY, no grant -> EMPTY.
  - FULL, res_ready=0 -> FULL; register contents held stable; no grant.
  - FULL, res_ready=1, grant -> FULL; new result replaces the old one in the same cycle.
  - FULL, res_ready=1, no grant -> EMPTY.
- Latency: request accepted at cycle N gives res_valid=1 at cycle N+1.
- Throughput: 1 op/cycle while res_ready=1.
- The static tag is not interpreted. A tag whose MSB is 0 (no writeback) still occupies a slot and produces res_valid.
- res_result/res_static retain their last value when res_valid=0. Only res_valid is meaningful to consumers.

Test Plan:
- Reset, then req0 alone (op=0, operands 5 and 3, static=6'b1_00100), res_ready=1 -> req0_ready=1 in that cycle. Next cycle: res_valid=1, res_result equals ALU result, res_static=6'b1_00100, res_src=0.
- Both requesters valid for 4 cycles with res_ready=1, pointer at reset value -> grants 0,1,0,1. res_src sequence 0,1,0,1 one cycle later. No cycle has two readies.
- Result held with res_ready=0 for 3 cycles while both are valid -> req0_ready=req1_ready=0. res_* stable, pointer unchanged. On res_ready=1, the favoured requester is granted the same cycle and the new result appears next cycle.
- req1 valid continuously, req0 asserts after 2 cycles -> req0 granted within 1 cycle of contention. req1 is never granted twice in a row while req0 waits.
- Reset asserted while res_valid=1 and both valid -> next cycle res_valid=0, both readies 0 during reset. After release, req0 wins first.
- Tag with MSB=0 (6'b0_11111) from req1 -> res_valid=1, res_static=6'b0_11111, res_src=1. The ALU inputs are 0 in all idle cycles.
